// File: rtl/obstacle_spawner.sv
// Obstacle lane generator: a step timer shifts the lane and spawns from the LFSR word.
// Define OBSTACLE_SPEEDUP_EN to shorten the step period every 16 points of score.
module obstacle_spawner #(
  parameter int LANE_LEN     = 8,
  parameter int TICK_DIV     = 1000,
  parameter int MIN_GAP      = 2,
  parameter int SPAWN_THRESH = 64
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Run,
  input  logic [15:0]         Rnd,
  output logic                LfsrEn,
  output logic                Step,
  output logic [LANE_LEN-1:0] Lane,
  output logic [15:0]         Score
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [3:0]    GAP_LOAD = 4'(MIN_GAP);
  localparam logic [8:0]    THRESH   = 9'(SPAWN_THRESH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]          r_state;
  logic [TW-1:0]       r_tick;
  logic [3:0]          r_gap;
  logic [LANE_LEN-1:0] r_lane;
  logic [15:0]         r_score;
  logic                r_step;
  logic                r_lfsrEn;

  logic w_term;
  logic w_stepEv;
  logic w_spawn;
  logic w_scoreInc;
  logic w_unusedRnd;

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [TW-1:0] DIV_STEP  = TW'(TICK_DIV / 8);
  localparam logic [TW-1:0] DIV_FLOOR = TW'(TICK_DIV / 4);
  localparam logic [TW-1:0] DIV_KNEE  = TW'(TICK_DIV / 4 + TICK_DIV / 8);

  logic [TW-1:0] r_div;

  // A shrunken period may leave the counter past the new terminal value, hence >=.
  assign w_term = (r_tick >= r_div - TICK_ONE);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_div <= TW'(TICK_DIV);
    end else if (w_stepEv && w_scoreInc && (r_score[3:0] == 4'hF)) begin
      r_div <= (r_div > DIV_KNEE) ? (r_div - DIV_STEP) : DIV_FLOOR;
    end
  end
`else
  localparam logic [TW-1:0] TICK_TERM = TW'(TICK_DIV - 1);

  assign w_term = (r_tick == TICK_TERM);
`endif

  assign w_stepEv    = Run && (r_state != S_IDLE) && w_term;
  assign w_spawn     = (r_state == S_RUN) && ({1'b0, Rnd[7:0]} < THRESH);
  assign w_scoreInc  = r_lane[LANE_LEN-1] && (r_score != 16'hFFFF);
  assign w_unusedRnd = ^Rnd[15:8];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_gap    <= '0;
      r_lane   <= '0;
      r_score  <= '0;
      r_step   <= 1'b0;
      r_lfsrEn <= 1'b0;
    end else begin
      r_step   <= 1'b0;
      r_lfsrEn <= 1'b0;
      if (Run) begin
        case (r_state)
          S_IDLE: r_state <= S_RUN;
          default: begin
            if (w_stepEv) begin
              r_tick   <= '0;
              r_step   <= 1'b1;
              r_lfsrEn <= 1'b1;
              r_lane   <= {r_lane[LANE_LEN-2:0], w_spawn};
              if (w_scoreInc) r_score <= r_score + 16'd1;
              // A spawn arms the gap counter; the last forced-empty step reopens RUN.
              if (w_spawn) begin
                r_state <= S_GAP;
                r_gap   <= GAP_LOAD;
              end else if (r_state == S_GAP) begin
                r_gap <= r_gap - 4'd1;
                if (r_gap <= 4'd1) r_state <= S_RUN;
              end
            end else begin
              r_tick <= r_tick + TICK_ONE;
            end
          end
        endcase
      end
    end
  end

  assign Lane   = r_lane;
  assign Score  = r_score;
  assign Step   = r_step;
  assign LfsrEn = r_lfsrEn;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomized self-checking bench for obstacle_spawner against a step-level behavioural model.
module tb_obstacle_spawner;

  localparam int LANE_LEN     = 8;
  localparam int TICK_DIV     = 4;
  localparam int MIN_GAP      = 2;
  localparam int SPAWN_THRESH = 64;
  localparam int LANE_TOP     = 1 << (LANE_LEN - 1);
  localparam int LANE_MOD     = 1 << LANE_LEN;

  logic                Clk = 1'b0;
  logic                Rst = 1'b0;
  logic                Run = 1'b0;
  logic [15:0]         Rnd = 16'h0000;
  logic                LfsrEn;
  logic                Step;
  logic [LANE_LEN-1:0] Lane;
  logic [15:0]         Score;

  int checkCount = 0;
  int passCount  = 0;

  bit mStarted;
  int mTicks;
  int mGapLeft;
  int mLane;
  int mScore;
  bit mStep;
  bit mLfsr;
  bit mSpawned;
  bit preloadReq = 1'b0;

  obstacle_spawner #(
    .LANE_LEN    (LANE_LEN),
    .TICK_DIV    (TICK_DIV),
    .MIN_GAP     (MIN_GAP),
    .SPAWN_THRESH(SPAWN_THRESH)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Run   (Run),
    .Rnd   (Rnd),
    .LfsrEn(LfsrEn),
    .Step  (Step),
    .Lane  (Lane),
    .Score (Score)
  );

  always #5 Clk = ~Clk;

  // Model: mGapLeft is the number of upcoming steps that must stay empty.
  always @(posedge Clk) begin
    mStep    = 1'b0;
    mLfsr    = 1'b0;
    mSpawned = 1'b0;
    if (!Rst) begin
      mStarted = 1'b0;
      mTicks   = 0;
      mGapLeft = 0;
      mLane    = 0;
      mScore   = 0;
    end else if (Run) begin
      if (!mStarted) begin
        mStarted = 1'b1;
      end else if (mTicks == TICK_DIV - 1) begin
        mTicks   = 0;
        mStep    = 1'b1;
        mLfsr    = 1'b1;
        mSpawned = (mGapLeft == 0) && (int'(Rnd[7:0]) < SPAWN_THRESH);
        if (mLane >= LANE_TOP) mScore = (mScore < 65535) ? mScore + 1 : 65535;
        mLane = ((mLane * 2) % LANE_MOD) + (mSpawned ? 1 : 0);
        if (mSpawned) mGapLeft = MIN_GAP;
        else if (mGapLeft > 0) mGapLeft = mGapLeft - 1;
      end else begin
        mTicks = mTicks + 1;
      end
    end
    if (preloadReq) mScore = 65535;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic rst, input logic run, input logic [15:0] rnd);
    Rst = rst;
    Run = run;
    Rnd = rnd;
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("Lane",   32'(Lane),   32'(mLane));
    checkOutput("Score",  32'(Score),  32'(mScore));
    checkOutput("Step",   32'(Step),   32'(mStep));
    checkOutput("LfsrEn", 32'(LfsrEn), 32'(mLfsr));
  endtask

  initial begin
    int pulses;
    int n;
    bit found;
    logic [7:0] seen [4];
    logic [7:0] expSeq [4];
    expSeq = '{8'h01, 8'h02, 8'h04, 8'h09};
    seen   = '{8'h00, 8'h00, 8'h00, 8'h00};

    // Reset then idle with Run low
    applyStimulus(1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    pulses = 0;
    repeat (20) begin
      applyStimulus(1'b1, 1'b0, 16'h0000);
      if (Step || LfsrEn) pulses++;
    end
    checkOutput("idlePulses", 32'(pulses), 32'd0);
    checkOutput("idleLane", 32'(Lane), 32'h00);

    // Spawn and gap sequence
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      applyStimulus(1'b1, 1'b1, 16'h0010);
      if (Step) begin
        seen[n] = Lane;
        n++;
      end
    end
    checkOutput("spawnSteps", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("spawnLane", 32'(seen[i]), 32'(expSeq[i]));

    // First obstacle leaves the player column
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b1, 1'b1, 16'h0010);
      if (Score != 16'd0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("scoreFound", 32'(found), 32'd1);
    checkOutput("scoreFirst", 32'(Score), 32'd1);
    checkOutput("scoreOnStep", 32'(Step), 32'd1);

    // No spawns: one LfsrEn pulse per TICK_DIV cycles
    pulses = 0;
    repeat (40) begin
      applyStimulus(1'b1, 1'b1, 16'h00FF);
      if (LfsrEn) pulses++;
    end
    checkOutput("noSpawnPulses", 32'(pulses), 32'd10);
    checkOutput("noSpawnLane", 32'(Lane), 32'h00);

    // Pause with the tick counter at 2
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mTicks == 2) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 1'b1, 16'h00FF);
    end
    checkOutput("pauseAlign", 32'(found), 32'd1);
    pulses = 0;
    repeat (10) begin
      applyStimulus(1'b1, 1'b0, 16'h0010);
      if (Step || LfsrEn) pulses++;
    end
    checkOutput("pausePulses", 32'(pulses), 32'd0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 16'h00FF);
      n++;
      if (Step) break;
    end
    checkOutput("resumeDelay", 32'(n), 32'd2);

    // Score saturation from a preloaded maximum
    force dut.r_score = 16'hFFFF;
    preloadReq = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0010);
    release dut.r_score;
    preloadReq = 1'b0;
    repeat (60) applyStimulus(1'b1, 1'b1, 16'h0010);
    checkOutput("scoreSat", 32'(Score), 32'hFFFF);

    // Reset one cycle after a spawn
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 1'b1, 16'h0010);
      if (mSpawned) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("gapSpawnFound", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0010);
    checkOutput("rstLane", 32'(Lane), 32'h00);
    checkOutput("rstScore", 32'(Score), 32'd0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b1, 16'h0010);
      n++;
      if (Step) break;
    end
    checkOutput("rstFirstStep", 32'(n), 32'd5);

    // Random traffic with pauses and occasional resets
    repeat (400) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0), 16'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
